// File: rtl/kbd_scan_display.sv
// PS/2 scancode history shown as hex on a multiplexed 7-segment display.
// Optional prefix decoding keeps make codes only, with E0-extended codes flagged on the dp.
module kbd_scan_display #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter bit          FILTER_BREAK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kbd_ready,
  input  logic [7:0]        kbd_data,
  input  logic              hold,
  input  logic              clr,
  output logic [7:0]        SEG,
  output logic [DIGITS-1:0] AN,
  output logic [15:0]       event_cnt
);

  localparam int unsigned DEPTH = DIGITS / 2;
  localparam int unsigned DW    = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW    = $clog2(SCAN_DIV);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          store, store_ext, do_store;
  logic [8:0]    hist_q [DEPTH];
  logic [CW-1:0] div_q;
  logic [DW-1:0] d_q;
  logic [8:0]    cur_entry;
  logic [3:0]    nib;
  logic [6:0]    hex;

  wire is_e0 = (kbd_data == 8'hE0);
  wire is_f0 = (kbd_data == 8'hF0);

  always_comb begin
    state_d   = state_q;
    store     = 1'b0;
    store_ext = 1'b0;
    if (kbd_ready) begin
      if (!FILTER_BREAK) begin
        store = 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (is_e0)      state_d = StExt;
            else if (is_f0) state_d = StBrk;
            else            store   = 1'b1;
          end
          StExt: begin
            if (is_f0) begin
              state_d = StExtBrk;
            end else if (!is_e0) begin
              store     = 1'b1;
              store_ext = 1'b1;
              state_d   = StIdle;
            end
          end
          StBrk: begin
            if (is_e0)       state_d = StExtBrk;
            else if (!is_f0) state_d = StIdle;
          end
          default: begin
            if (!is_e0 && !is_f0) state_d = StIdle;
          end
        endcase
      end
    end
  end

  // hold freezes the history only; the decoder keeps following prefixes
  assign do_store = store & ~hold & ~clr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= StIdle;
      event_cnt <= 16'h0000;
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (do_store) begin
        for (int k = DEPTH - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
        hist_q[0] <= {store_ext, kbd_data};
        event_cnt <= event_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    cur_entry = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((d_q >> 1) == DW'(k)) cur_entry = hist_q[k];
    end
    nib = d_q[0] ? cur_entry[7:4] : cur_entry[3:0];
  end

  always_comb begin
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      d_q   <= '0;
      AN    <= '1;
      SEG   <= 8'hFF;
    end else begin
      if (div_q == CW'(SCAN_DIV - 1)) begin
        div_q <= '0;
        d_q   <= (d_q == DW'(DIGITS - 1)) ? '0 : d_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      AN  <= ~(DIGITS'(1) << d_q);
      // dp marks an extended code on the high-nibble digit of its entry
      SEG <= {~(d_q[0] & cur_entry[8]), hex};
    end
  end

endmodule
